// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO-side handshake for the UART transmit drain: the transmitter pulls words
// from a first-word-fall-through FIFO using a single read strobe.
interface uart_tx_fifo_drain_if #(
    parameter int WIDTH = 8
);
    logic             i_empty;
    logic [WIDTH-1:0] i_data;
    logic             o_re;

    modport master (input i_empty, input i_data, output o_re);
    modport slave  (output i_empty, output i_data, input o_re);
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains words from an upstream FIFO, one frame per word,
// with optional parity and one or two stop bits.
module uart_tx_fifo_drain #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_en,
    uart_tx_fifo_drain_if.master        fifo,
    output logic                        o_tx,
    output logic                        o_busy,
    output logic                        o_done
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(WIDTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST  = IW'(WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST  = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [IW-1:0]    bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             rd_en;
    logic             bit_end;
    logic             parity_nxt;

    // Reset gates the strobe so no word is popped during the reset cycle.
    assign rd_en      = (state_q == IDLE) & i_en & ~fifo.i_empty & i_rst_n;
    assign bit_end    = (timer_q == TIMER_LAST);
    assign parity_nxt = parity_q ^ shift_q[0];

    assign fifo.o_re = rd_en;
    assign o_tx      = tx_q;
    assign o_busy    = (state_q != IDLE);
    assign o_done    = done_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        done_d    = 1'b0;

        if (state_q != IDLE) begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (rd_en) begin
                    shift_d   = fifo.i_data;
                    parity_d  = 1'b0;
                    timer_d   = '0;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d  = shift_q >> 1;
                    parity_d = parity_nxt;
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
                        if (PARITY != 0) begin
                            tx_d    = (PARITY == 2) ? ~parity_nxt : parity_nxt;
                            state_d = PAR;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    tx_d      = 1'b1;
                    bit_idx_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                // The bit index doubles as the stop-bit counter.
                if (bit_end) begin
                    if (bit_idx_q == STOP_LAST) begin
                        bit_idx_d = '0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: a no-parity instance fed by a FIFO model plus
// even- and odd-parity instances, with frames checked against a scoreboard.
module tb_uart_tx_fifo_drain;
    localparam int CPB = 4;

    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [10:0] frame;
        int          nbits;
    } vec_t;

    logic clk;
    logic rst_n;
    logic en0, en1, en2;
    logic o_tx0, o_tx1, o_tx2;
    logic o_busy0, o_busy1, o_busy2;
    logic o_done0, o_done1, o_done2;

    uart_tx_fifo_drain_if #(.WIDTH(8)) fif0 ();
    uart_tx_fifo_drain_if #(.WIDTH(8)) fif1 ();
    uart_tx_fifo_drain_if #(.WIDTH(8)) fif2 ();

    uart_tx_fifo_drain #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en0), .fifo(fif0.master),
        .o_tx(o_tx0), .o_busy(o_busy0), .o_done(o_done0));
    uart_tx_fifo_drain #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en1), .fifo(fif1.master),
        .o_tx(o_tx1), .o_busy(o_busy1), .o_done(o_done1));
    uart_tx_fifo_drain #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en2), .fifo(fif2.master),
        .o_tx(o_tx2), .o_busy(o_busy2), .o_done(o_done2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  fifo_q[$];
    logic [10:0] exp_q[$];
    bit          model_on;
    logic        tx_s[3], busy_s[3], done_s[3], re_s[3];
    vec_t        vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void driveModel();
        fif0.i_empty = (fifo_q.size() == 0);
        fif0.i_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endfunction

    // One clock: sample outputs mid-cycle, then apply the FIFO pop after the edge.
    task automatic tick();
        @(negedge clk);
        tx_s[0] = o_tx0;  busy_s[0] = o_busy0; done_s[0] = o_done0; re_s[0] = fif0.o_re;
        tx_s[1] = o_tx1;  busy_s[1] = o_busy1; done_s[1] = o_done1; re_s[1] = fif1.o_re;
        tx_s[2] = o_tx2;  busy_s[2] = o_busy2; done_s[2] = o_done2; re_s[2] = fif2.o_re;
        @(posedge clk);
        #1;
        if (model_on && re_s[0] === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (model_on) driveModel();
    endtask

    task automatic applyStimulus(input int sel, input logic [7:0] data, input logic [10:0] frame);
        exp_q.push_back(frame);
        if (sel == 0) begin
            fifo_q.push_back(data);
            driveModel();
        end else begin
            fif1.i_data = data;  fif2.i_data = data;
            fif1.i_empty = 1'b0; fif2.i_empty = 1'b0;
            en1 = (sel == 1);
            en2 = (sel == 2);
        end
    endtask

    task automatic waitForRe(input int sel, input string name);
        int n = 0;
        while (re_s[sel] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checkOutput({name, " re seen"}, 32'(re_s[sel] === 1'b1), 32'd1);
    endtask

    // Collects one frame starting the cycle after o_re, then checks the done cycle.
    task automatic receiveFrame(input int sel, input int nbits, input bit perturb, input string name);
        logic [10:0] got = '0;
        logic [10:0] expv;
        int bad_hold = 0, busy_cnt = 0, stray = 0;
        int total = nbits * CPB;
        for (int c = 0; c < total; c++) begin
            tick();
            if (c % CPB == 0) got[c / CPB] = tx_s[sel];
            else if (tx_s[sel] !== got[c / CPB]) bad_hold++;
            if (busy_s[sel] === 1'b1) busy_cnt++;
            if (re_s[sel] !== 1'b0 || done_s[sel] !== 1'b0) stray++;
            if (perturb) begin
                fif0.i_empty = (c == total - 1) ? 1'b1 : 1'($urandom_range(0, 1));
                fif0.i_data  = 8'($urandom);
            end
        end
        tick();
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7FF;
        checkOutput({name, " frame"}, 32'(got), 32'(expv));
        checkOutput({name, " bit hold"}, 32'(bad_hold), 32'd0);
        checkOutput({name, " busy cycles"}, 32'(busy_cnt), 32'(total));
        checkOutput({name, " re/done mid-frame"}, 32'(stray), 32'd0);
        checkOutput({name, " done/busy/tx after"}, 32'({done_s[sel], busy_s[sel], tx_s[sel]}), 32'b101);
    endtask

    initial begin
        int re_cnt, low_cnt, busy_cnt;

        vecs[0] = '{0, 8'hA5, 11'h34A, 10};
        vecs[1] = '{0, 8'h00, 11'h200, 10};
        vecs[2] = '{0, 8'hFF, 11'h3FE, 10};
        vecs[3] = '{0, 8'h81, 11'h302, 10};
        vecs[4] = '{1, 8'h07, 11'h60E, 11};
        vecs[5] = '{2, 8'h07, 11'h40E, 11};
        vecs[6] = '{1, 8'hA5, 11'h54A, 11};
        vecs[7] = '{2, 8'hA5, 11'h74A, 11};

        for (int i = 0; i < 3; i++) begin
            tx_s[i] = 1'b0; busy_s[i] = 1'b0; done_s[i] = 1'b0; re_s[i] = 1'b0;
        end
        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; en2 = 1'b0; model_on = 1'b1;
        fif1.i_empty = 1'b1; fif2.i_empty = 1'b1; fif1.i_data = 8'h00; fif2.i_data = 8'h00;
        driveModel();
        tick();
        tick();

        // Reset held with a word waiting and fetch enabled
        en0 = 1'b1;
        applyStimulus(0, 8'h5A, 11'h2B4);
        tick();
        tick();
        checkOutput("reset tx", 32'(tx_s[0]), 32'd1);
        checkOutput("reset busy", 32'(busy_s[0]), 32'd0);
        checkOutput("reset done", 32'(done_s[0]), 32'd0);
        checkOutput("reset re", 32'(re_s[0]), 32'd0);
        checkOutput("reset tx par", 32'({tx_s[1], tx_s[2]}), 32'b11);
        rst_n = 1'b1;
        waitForRe(0, "first");
        receiveFrame(0, 10, 1'b0, "5A");

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].data, vecs[i].frame);
            waitForRe(vecs[i].sel, $sformatf("vec%0d", i));
            if (vecs[i].sel != 0) begin
                fif1.i_empty = 1'b1; fif2.i_empty = 1'b1;
                en1 = 1'b0; en2 = 1'b0;
            end
            receiveFrame(vecs[i].sel, vecs[i].nbits, 1'b0, $sformatf("vec%0d", i));
        end

        // Back-to-back words: next o_re lands on the done cycle
        applyStimulus(0, 8'h01, 11'h202);
        applyStimulus(0, 8'h02, 11'h204);
        applyStimulus(0, 8'h03, 11'h206);
        waitForRe(0, "b2b");
        receiveFrame(0, 10, 1'b0, "b2b 01");
        checkOutput("b2b re after 01", 32'(re_s[0]), 32'd1);
        receiveFrame(0, 10, 1'b0, "b2b 02");
        checkOutput("b2b re after 02", 32'(re_s[0]), 32'd1);
        receiveFrame(0, 10, 1'b0, "b2b 03");
        checkOutput("b2b re after 03", 32'(re_s[0]), 32'd0);

        // Fetch disabled with a non-empty FIFO
        en0 = 1'b0;
        applyStimulus(0, 8'h11, 11'h222);
        re_cnt = 0; low_cnt = 0; busy_cnt = 0;
        repeat (30) begin
            tick();
            if (re_s[0] !== 1'b0) re_cnt++;
            if (tx_s[0] !== 1'b1) low_cnt++;
            if (busy_s[0] !== 1'b0) busy_cnt++;
        end
        checkOutput("en off re", 32'(re_cnt), 32'd0);
        checkOutput("en off tx low", 32'(low_cnt), 32'd0);
        checkOutput("en off busy", 32'(busy_cnt), 32'd0);
        en0 = 1'b1;
        waitForRe(0, "en on");
        receiveFrame(0, 10, 1'b0, "11");

        // Upstream churn mid-frame must not disturb the word in flight
        applyStimulus(0, 8'h3C, 11'h278);
        waitForRe(0, "churn");
        model_on = 1'b0;
        receiveFrame(0, 10, 1'b1, "3C churn");
        model_on = 1'b1;
        driveModel();

        // Reset in the middle of data bit 3 drops the word
        fifo_q.push_back(8'hC3);
        driveModel();
        waitForRe(0, "rst mid");
        repeat (18) tick();
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("mid reset tx", 32'(tx_s[0]), 32'd1);
        checkOutput("mid reset busy", 32'(busy_s[0]), 32'd0);
        checkOutput("mid reset done", 32'(done_s[0]), 32'd0);
        applyStimulus(0, 8'h96, 11'h32C);
        tick();
        checkOutput("mid reset re", 32'(re_s[0]), 32'd0);
        rst_n = 1'b1;
        waitForRe(0, "after rst");
        receiveFrame(0, 10, 1'b0, "96");

        // Fetch dropped mid-frame: frame completes, nothing further fetched
        applyStimulus(0, 8'h55, 11'h2AA);
        applyStimulus(0, 8'h66, 11'h2CC);
        waitForRe(0, "en drop");
        en0 = 1'b0;
        receiveFrame(0, 10, 1'b0, "55");
        checkOutput("en drop re at done", 32'(re_s[0]), 32'd0);
        re_cnt = 0; low_cnt = 0;
        repeat (20) begin
            tick();
            if (re_s[0] !== 1'b0) re_cnt++;
            if (tx_s[0] !== 1'b1) low_cnt++;
        end
        checkOutput("en drop re after", 32'(re_cnt), 32'd0);
        checkOutput("en drop tx low", 32'(low_cnt), 32'd0);
        en0 = 1'b1;
        waitForRe(0, "drain");
        receiveFrame(0, 10, 1'b0, "66");

        checkOutput("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
